// File: rtl/lifo_pkg.sv
// Shared widths and operation encoding for the LIFO stack.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  // Count must reach DEPTH itself, so it needs one more code than an address.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// Purpose: DEPTH x WIDTH register file for the stack, contents never reset.
// Latency: write lands on the rising edge, read is combinational.
// Backpressure: none; the caller only asserts we for legal addresses.
module lifo_mem
  import lifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Purpose: LIFO stack with registered pop data, full/empty/count and error pulses.
// Latency: popped word on data_out one edge after pop; status same-cycle as the edge.
// Backpressure: none; push when full / pop when empty are dropped and flagged.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     empty,
  output logic                     full,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = addr_w(DEPTH);

  logic [CW-1:0]    sp;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] top_data;
  logic             we;
  op_e              op;

  assign empty    = (sp == '0);
  assign full     = (sp == CW'(DEPTH));
  assign count    = sp;
  assign top_addr = AW'(sp - CW'(1));

  always_comb begin
    op = OP_IDLE;
    if (push && pop) begin
      op = OP_REPLACE;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end
  end

  // A replace on an empty stack degenerates to a push into slot 0.
  always_comb begin
    we    = 1'b0;
    waddr = AW'(sp);
    case (op)
      OP_PUSH:    we = !full;
      OP_REPLACE: begin
        we = 1'b1;
        if (!empty) begin
          waddr = top_addr;
        end
      end
      default:    we = 1'b0;
    endcase
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_in),
    .raddr (top_addr),
    .rdata (top_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      case (op)
        OP_PUSH: begin
          if (full) begin
            overflow <= 1'b1;
          end else begin
            sp <= sp + CW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            data_out <= top_data;
            sp       <= sp - CW'(1);
          end
        end
        OP_REPLACE: begin
          if (empty) begin
            sp        <= CW'(1);
            underflow <= 1'b1;
          end else begin
            data_out <= top_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed test of lifo_stack (WIDTH=16, DEPTH=4) with hand-computed expectations.
module tb_lifo_stack;

  logic        clk;
  logic        rst;
  logic        push;
  logic        pop;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int n_chk = 0;
  int n_err = 0;

  lifo_stack #(
    .WIDTH (16),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: inputs applied at the falling edge, outputs settle 1ns after the rising edge.
  task automatic cyc(input logic p, input logic q, input logic [15:0] d);
    @(negedge clk);
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] fill_vals [4];
    fill_vals[0] = 16'h1111;
    fill_vals[1] = 16'h2222;
    fill_vals[2] = 16'h3333;
    fill_vals[3] = 16'h4444;

    rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, fill_vals[i]);
      chk("fill_count", count, i + 1);
    end
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);

    cyc(1, 0, 16'h5555);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count, 4);
    cyc(0, 0, 16'h0000);
    chk("ovf_clear", overflow, 0);

    for (int i = 3; i >= 0; i--) begin
      cyc(0, 1, 16'h0000);
      chk("drain_dout", data_out, fill_vals[i]);
      chk("drain_count", count, i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);

    cyc(0, 1, 16'h0000);
    chk("udf_pulse", underflow, 1);
    chk("udf_dout_hold", data_out, 16'h1111);
    chk("udf_count", count, 0);
    cyc(0, 0, 16'h0000);
    chk("udf_clear", underflow, 0);

    cyc(1, 0, 16'hAAAA);
    chk("rep_push_count", count, 1);
    cyc(1, 1, 16'hBBBB);
    chk("rep_dout", data_out, 16'hAAAA);
    chk("rep_count", count, 1);
    chk("rep_ovf", overflow, 0);
    chk("rep_udf", underflow, 0);
    cyc(0, 1, 16'h0000);
    chk("rep_pop", data_out, 16'hBBBB);
    chk("rep_empty", empty, 1);

    // Push+pop on an empty stack behaves as a push and flags underflow.
    cyc(1, 1, 16'hCCCC);
    chk("rep_empty_count", count, 1);
    chk("rep_empty_udf", underflow, 1);
    chk("rep_empty_dout", data_out, 16'hBBBB);
    cyc(0, 1, 16'h0000);
    chk("rep_empty_pop", data_out, 16'hCCCC);
    chk("rep_empty_udf_clr", underflow, 0);

    cyc(1, 0, 16'h0101);
    cyc(1, 0, 16'h0202);
    cyc(1, 0, 16'h0303);
    cyc(1, 0, 16'h0404);
    chk("full2", full, 1);
    cyc(1, 1, 16'h0F0F);
    chk("rep_full_dout", data_out, 16'h0404);
    chk("rep_full_count", count, 4);
    chk("rep_full_ovf", overflow, 0);
    cyc(0, 1, 16'h0000);
    chk("rep_full_pop", data_out, 16'h0F0F);
    chk("pre_arst_count", count, 3);

    // Reset asserted between edges must clear state without waiting for clk.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_count", count, 0);
    chk("arst_dout", data_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 1, 16'h0000);
    chk("post_arst_udf", underflow, 1);
    chk("post_arst_count", count, 0);
    chk("post_arst_dout", data_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parameterised last-in-first-out stack with single-port push/pop, registered read data and full/empty status. It is a general-purpose buffering block: a producer pushes words, and a consumer pops them in reverse order. Everything runs in one clock domain and is used standalone or as a leaf under a wrapper.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2, need not be a power of two)
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- push  input  1  write data_in onto the stack this cycle
- pop  input  1  remove the top entry and present it on data_out
- data_in  input  WIDTH  word to push
- data_out  output  WIDTH  last popped word (registered)
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  $clog2(DEPTH+1)  number of valid entries
- overflow  output  1  one-cycle pulse: push rejected because the stack was full
- underflow  output  1  one-cycle pulse: pop rejected because the stack was empty

## Operation
- Storage: DEPTH×WIDTH array. The stack pointer sp equals count; the top entry is mem[sp-1].
- Push only, not full: mem[sp] <= data_in; sp <= sp+1.
- Push only, full: no state change; overflow pulses.
- Pop only, not empty: data_out <= mem[sp-1]; sp <= sp-1.
- Pop only, empty: no state change; data_out holds; underflow pulses.
- Push and pop together, not empty (including full): data_out <= mem[sp-1]; mem[sp-1] <= data_in; sp unchanged. This is a replace-top operation. No overflow or underflow.
- Push and pop together, empty: treated as push only (sp <= 1). data_out holds. underflow pulses.
- Neither asserted: data_out, sp and the memory all hold.
- empty and full are decoded combinationally from sp; they are never both 1.
- Memory contents are not reset. Only sp, data_out and the pulse flags are reset.

## Timing
- All state updates on the rising edge of clk.
- Reset (rst low) acts immediately, independent of clk: sp=0, data_out=0, empty=1, full=0, count=0, overflow=0, underflow=0.
- Reset deasserts asynchronously. The first operation is sampled at the first rising edge with rst high.
- Reset asserted mid-operation discards all stored entries. The stack reads empty immediately.
- Pop latency: data_out carries the popped word from the edge that sampled pop until the next successful pop.
- empty, full and count reflect a push or pop in the same cycle the edge completes; there is no extra latency.
- overflow and underflow are registered and high for exactly the one cycle after the offending edge.
- No handshake. push and pop are qualified only by clk and by the full/empty state.

## Structure
- Package lifo_pkg holds the pointer/count width functions (clog2-based) and the operation encoding enum {OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE}.
- One sub-module, lifo_mem: DEPTH×WIDTH register file with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata).
- The top level contains the sp counter, operation decode, data_out register and flag logic.

## Test plan
All scenarios use WIDTH=16, DEPTH=4.
- Reset: hold rst=0 for 2 cycles -> empty=1, full=0, count=0, data_out=0x0000.
- Fill and drain: push 0x1111, 0x2222, 0x3333, 0x4444 -> full=1, count=4. Then pop 4 times -> data_out = 0x4444, 0x3333, 0x2222, 0x1111 on successive cycles; empty=1 at the end.
- Overflow: with the stack full, push 0x5555 -> count stays 4, overflow pulses for 1 cycle. The next pop returns 0x4444.
- Underflow: with the stack empty, pop -> data_out holds its last value, underflow pulses for 1 cycle, count stays 0.
- Replace: push 0xAAAA, then push+pop with data_in=0xBBBB -> data_out=0xAAAA, count=1. The next pop returns 0xBBBB.
- Async reset mid-run: after 3 pushes, drive rst low between clock edges -> empty=1 and count=0 before the next edge. After release, a pop underflows.
